laser_gun_tx: RTL
=================

// Module: laser_gun_tx
// PURPOSE
//  Transmitter end of the duck-hunt laser link: turns a player's trigger button into one fixed-length laser
//  shot on a GPIO_0 output pin, which the photoresistor targets detect. Enforces ammo count, inter-shot
//  recovery and timed reload. One instance per gun; outputs feed GPIO_0 laser pins, LEDR ammo bar and sound.
// PARAMETERS
//  DEBOUNCE_CYCLES  500_000      trigger/reload must be stable this many cycles (10 ms @ 50 MHz)
//  SHOT_CYCLES      2_500_000    laser on-time per shot (50 ms)
//  RECOVER_CYCLES   25_000_000   dead time after a shot before the next may fire (0.5 s)
//  RELOAD_CYCLES    100_000_000  reload duration (2 s)
//  AMMO_MAX         6            rounds after reset/reload; 1..15
//  MOD_HALF_CYCLES  1_250        carrier half-period, LASER_MOD_EN builds only (20 kHz)
// PORTS
//  CLOCK_50  in   1  system clock, 50 MHz; only clock
//  RESET     in   1  synchronous, active-high reset
//  TRIGGER   in   1  raw trigger button, asynchronous, active-high
//  RELOAD    in   1  raw reload button, asynchronous, active-high
//  LASER     out  1  laser driver (GPIO_0 pin), 1 = emitting
//  AMMO      out  4  rounds remaining
//  FIRED     out  1  one-cycle pulse when a shot starts (to score/beep logic)
//  EMPTY     out  1  AMMO == 0
//  BUSY      out  1  state != IDLE
// BEHAVIOUR
//  - Reset (sync, active-high): state IDLE, LASER=0, FIRED=0, AMMO=AMMO_MAX, EMPTY=0, BUSY=0, all counters 0,
//    debouncers cleared to released. Reset mid-shot/mid-reload drops LASER on the same clock edge.
//  - Inputs: 2-flop synchronizer, then debounce; only a debounced 0->1 edge is an event. Holding the trigger
//    fires once; release + re-press needed for the next shot.
//  - FSM: IDLE, FIRE, RECOVER, RELOADING.
//    IDLE: reload event -> RELOADING (wins over simultaneous trigger event).
//          trigger event & AMMO>0 -> FIRE; same edge: FIRED=1, AMMO-=1, LASER=1 from next cycle.
//          trigger event & AMMO==0 -> stay IDLE, no FIRED, LASER stays 0.
//    FIRE: LASER=1 for exactly SHOT_CYCLES cycles, then -> RECOVER.
//    RECOVER: LASER=0 for RECOVER_CYCLES cycles, then -> IDLE.
//    RELOADING: LASER=0; after RELOAD_CYCLES cycles AMMO=AMMO_MAX, -> IDLE. Reload when full still runs.
//  - Events arriving outside IDLE (trigger or reload) are discarded, not queued.
//  - Latency: debounced trigger edge -> FIRED same cycle as the FIRE transition; LASER high 1 cycle later.
//  - One shared down-counter for FIRE/RECOVER/RELOADING, width $clog2 of largest of the three; loaded on
//    state entry, terminal at 0. AMMO never underflows or exceeds AMMO_MAX.
// CONFIGURATION
//  LASER_MOD_EN defined: in FIRE, LASER toggles every MOD_HALF_CYCLES (starts high) so receivers can reject
//    ambient light; carrier counter resets on FIRE entry; LASER forced 0 outside FIRE.
//  LASER_MOD_EN undefined: LASER is steady 1 throughout FIRE; MOD_HALF_CYCLES unused.
// STRUCTURE
//  duck_hunt_pkg: gun_state_t enum (IDLE, FIRE, RECOVER, RELOADING), AMMO_W=4, default timing constants
//    shared with the target-side cooldown logic.
//  Sub-module: sync_debounce (2-flop sync + stable-count debounce + rising-edge pulse), instanced for
//    TRIGGER and RELOAD.
// TESTING  (bench overrides: DEBOUNCE=4, SHOT=10, RECOVER=20, RELOAD=50, AMMO_MAX=3, MOD_HALF=2)
//  1 Press TRIGGER 8 cycles from reset -> one FIRED pulse, AMMO 3->2, LASER high exactly 10 cycles, BUSY
//    high until RECOVER ends (30 cycles after FIRE entry).
//  2 Hold TRIGGER 200 cycles -> single shot only; AMMO=2.
//  3 Four press/release cycles spaced 60 cycles -> 3 shots, AMMO=0, EMPTY=1; 4th press: no FIRED, LASER 0.
//  4 RELOAD press while EMPTY -> RELOADING 50 cycles, AMMO=3, EMPTY=0; trigger during reload ignored.
//  5 Trigger and reload debounced edges on the same cycle in IDLE -> RELOADING, no FIRED, AMMO unchanged.
//  6 RESET asserted 5 cycles into FIRE -> LASER=0 next edge, AMMO=3, IDLE; with LASER_MOD_EN, LASER
//    pattern in FIRE is 1,1,0,0,... for 10 cycles.

Source files
------------

// File: rtl/duck_hunt_pkg.sv
// Shared duck-hunt definitions: gun FSM states, ammo width and default timing constants
// used by both the laser gun transmitter and the target-side cooldown logic.
package duck_hunt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FIRE      = 2'd1,
    RECOVER   = 2'd2,
    RELOADING = 2'd3
  } gun_state_t;

  localparam int AMMO_W = 4;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int unsigned DEF_SHOT_CYCLES     = 2_500_000;
  localparam int unsigned DEF_RECOVER_CYCLES  = 25_000_000;
  localparam int unsigned DEF_RELOAD_CYCLES   = 100_000_000;
  localparam int unsigned DEF_AMMO_MAX        = 6;
  localparam int unsigned DEF_MOD_HALF_CYCLES = 1_250;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/laser_gun_tx_if.sv
// Button inputs and laser/ammo/status outputs of one laser gun.
interface laser_gun_tx_if;
  import duck_hunt_pkg::*;

  logic              TRIGGER;
  logic              RELOAD;
  logic              LASER;
  logic [AMMO_W-1:0] AMMO;
  logic              FIRED;
  logic              EMPTY;
  logic              BUSY;

  modport master (output TRIGGER, RELOAD, input LASER, AMMO, FIRED, EMPTY, BUSY);
  modport slave  (input TRIGGER, RELOAD, output LASER, AMMO, FIRED, EMPTY, BUSY);
endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchronizer, stable-count debouncer and one-cycle rising-edge pulse
// for a raw asynchronous push button.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2, stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      // accept the new level only after DEBOUNCE_CYCLES consecutive differing samples
      if (s2 != stable) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable <= s2;
          rise   <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/laser_gun_tx.sv
// Laser gun transmitter: debounced trigger fires fixed-length shots, with ammo count,
// recovery dead time and timed reload. Optional carrier modulation: LASER_MOD_EN.
module laser_gun_tx
  import duck_hunt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SHOT_CYCLES     = DEF_SHOT_CYCLES,
  parameter int unsigned RECOVER_CYCLES  = DEF_RECOVER_CYCLES,
  parameter int unsigned RELOAD_CYCLES   = DEF_RELOAD_CYCLES,
  parameter int unsigned AMMO_MAX        = DEF_AMMO_MAX,
  parameter int unsigned MOD_HALF_CYCLES = DEF_MOD_HALF_CYCLES
) (
  input logic           CLOCK_50,
  input logic           RESET,
  laser_gun_tx_if.slave gun
);
  localparam int unsigned CNT_MAX = max3(SHOT_CYCLES, RECOVER_CYCLES, RELOAD_CYCLES);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(AMMO_MAX);

  gun_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [AMMO_W-1:0] ammo;
  logic              laser, fired, empty, busy;
  logic              trig_ev, reload_ev, carrier;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trig (
    .clk(CLOCK_50), .rst(RESET), .raw(gun.TRIGGER), .rise(trig_ev)
  );

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reload (
    .clk(CLOCK_50), .rst(RESET), .raw(gun.RELOAD), .rise(reload_ev)
  );

`ifdef LASER_MOD_EN
  localparam int MW = $clog2(MOD_HALF_CYCLES + 1);
  logic [MW-1:0] mod_cnt;
  logic          mod_ph;

  // carrier restarts high on every FIRE entry
  always_ff @(posedge CLOCK_50) begin
    if (RESET || state != FIRE) begin
      mod_cnt <= '0;
      mod_ph  <= 1'b1;
    end else if (mod_cnt == MW'(MOD_HALF_CYCLES - 1)) begin
      mod_cnt <= '0;
      mod_ph  <= ~mod_ph;
    end else begin
      mod_cnt <= mod_cnt + 1'b1;
    end
  end
  assign carrier = mod_ph;
`else
  assign carrier = 1'b1;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      ammo  <= AMMO_FULL;
      laser <= 1'b0;
      fired <= 1'b0;
      empty <= 1'b0;
      busy  <= 1'b0;
    end else begin
      fired <= 1'b0;
      // laser trails the state by one cycle so it is high exactly SHOT_CYCLES cycles
      laser <= (state == FIRE) && carrier;
      case (state)
        IDLE: begin
          if (reload_ev) begin
            state <= RELOADING;
            cnt   <= CNT_W'(RELOAD_CYCLES - 1);
            busy  <= 1'b1;
          end else if (trig_ev && ammo != '0) begin
            state <= FIRE;
            cnt   <= CNT_W'(SHOT_CYCLES - 1);
            busy  <= 1'b1;
            fired <= 1'b1;
            ammo  <= ammo - 1'b1;
            empty <= (ammo == AMMO_W'(1));
          end
        end
        FIRE: begin
          if (cnt == '0) begin
            state <= RECOVER;
            cnt   <= CNT_W'(RECOVER_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RECOVER: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RELOADING: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            ammo  <= AMMO_FULL;
            empty <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gun.LASER = laser;
  assign gun.AMMO  = ammo;
  assign gun.FIRED = fired;
  assign gun.EMPTY = empty;
  assign gun.BUSY  = busy;
endmodule
